// File: rtl/shift_register_array_multimode_pkg.sv
// Shared definitions for the multi-mode shift register array: mode encodings
// and a width helper for the saturating fill counter.
package shift_register_array_multimode_pkg;

  // Lane operating modes, sampled on every rising edge
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHL  = 2'b01;
  localparam logic [1:0] MODE_SHR  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  // Bits needed to count 0..depth inclusive
  function automatic int fill_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_register_array_multimode_lane.sv
// One lane of the array: a DEPTH-bit register with hold, shift left,
// shift right and parallel load. The enable is the global enable already
// masked with this lane's lane_enable bit.
module shift_register_lane
  import shift_register_array_multimode_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clear,
  input  logic [1:0]       mode,
  input  logic             in,
  input  logic [DEPTH-1:0] load_data,
  output logic [DEPTH-1:0] out
);

  logic [DEPTH-1:0] lane_q;
  logic [DEPTH-1:0] lane_d;

  // Next-state: clear beats everything, then the enabled mode, else hold
  always_comb begin
    lane_d = lane_q;
    if (clear) begin
      lane_d = '0;
    end else if (en) begin
      case (mode)
        MODE_SHL:  lane_d = {lane_q[DEPTH-2:0], in};
        MODE_SHR:  lane_d = {in, lane_q[DEPTH-1:1]};
        MODE_LOAD: lane_d = load_data;
        default:   lane_d = lane_q;
      endcase
    end
  end

  // Lane register with asynchronous clear on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane_q <= '0;
    end else begin
      lane_q <= lane_d;
    end
  end

  assign out = lane_q;

endmodule

// File: rtl/shift_register_array_multimode.sv
// Multi-lane shift register array. BIT_WIDTH independent lanes of DEPTH
// bits each, with per-lane enable masking and one shared saturating fill
// counter that follows global activity rather than any single lane.
module shift_register_array_multimode
  import shift_register_array_multimode_pkg::*;
#(
  parameter  int BIT_WIDTH = 8,
  parameter  int DEPTH     = 8,
  localparam int CW        = fill_width(DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [BIT_WIDTH-1:0]       lane_enable,
  input  logic                       clear,
  input  logic [1:0]                 mode,
  input  logic [BIT_WIDTH-1:0]       in,
  input  logic [BIT_WIDTH*DEPTH-1:0] load_data,
  output logic [BIT_WIDTH*DEPTH-1:0] out,
  output logic [BIT_WIDTH-1:0]       msb_out,
  output logic [BIT_WIDTH-1:0]       lsb_out,
  output logic [CW-1:0]              fill_count,
  output logic                       full
);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [CW-1:0] fill_q;
  logic [CW-1:0] fill_d;

  for (genvar i = 0; i < BIT_WIDTH; i++) begin : g_lane
    logic [DEPTH-1:0] lane_out;

    shift_register_lane #(
      .DEPTH(DEPTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .en       (enable & lane_enable[i]),
      .clear    (clear),
      .mode     (mode),
      .in       (in[i]),
      .load_data(load_data[i*DEPTH +: DEPTH]),
      .out      (lane_out)
    );

    assign out[i*DEPTH +: DEPTH] = lane_out;
    assign msb_out[i]            = lane_out[DEPTH-1];
    assign lsb_out[i]            = lane_out[0];
  end

  // Fill counter next-state: ignores lane_enable, saturates at DEPTH
  always_comb begin
    fill_d = fill_q;
    if (clear) begin
      fill_d = '0;
    end else if (enable) begin
      case (mode)
        MODE_SHL, MODE_SHR: begin
          if (fill_q != DEPTH_C) begin
            fill_d = fill_q + CW'(1);
          end
        end
        MODE_LOAD: fill_d = DEPTH_C;
        default:   fill_d = fill_q;
      endcase
    end
  end

  // Fill counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill_q <= '0;
    end else begin
      fill_q <= fill_d;
    end
  end

  assign fill_count = fill_q;
  assign full       = (fill_q == DEPTH_C);

endmodule

// File: tb/tb_shift_register_array_multimode.sv
// Scoreboard bench for shift_register_array_multimode: the driver updates an
// arithmetic reference model and queues the expected state; a monitor pops
// and compares after every rising edge or asynchronous reset.
module tb_shift_register_array_multimode;
  import shift_register_array_multimode_pkg::*;

  localparam int BW    = 8;
  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH + 1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  enable;
  logic [BW-1:0]         lane_enable;
  logic                  clear;
  logic [1:0]            mode;
  logic [BW-1:0]         in;
  logic [BW*DEPTH-1:0]   load_data;
  logic [BW*DEPTH-1:0]   out;
  logic [BW-1:0]         msb_out;
  logic [BW-1:0]         lsb_out;
  logic [CW-1:0]         fill_count;
  logic                  full;

  shift_register_array_multimode #(.BIT_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .lane_enable(lane_enable),
    .clear      (clear),
    .mode       (mode),
    .in         (in),
    .load_data  (load_data),
    .out        (out),
    .msb_out    (msb_out),
    .lsb_out    (lsb_out),
    .fill_count (fill_count),
    .full       (full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [BW*DEPTH-1:0] out;
    logic [BW-1:0]       msb;
    logic [BW-1:0]       lsb;
    int                  fill;
    logic                full;
    string               tag;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: lane values as plain integers, fill as an int
  int m_lane[BW];
  int m_fill;

  task automatic model_reset();
    for (int i = 0; i < BW; i++) m_lane[i] = 0;
    m_fill = 0;
  endtask

  task automatic model_step(input logic en, input logic [BW-1:0] le, input logic clr,
                            input logic [1:0] md, input logic [BW-1:0] inb,
                            input logic [BW*DEPTH-1:0] ld);
    logic [DEPTH-1:0] sl;
    if (clr) begin
      model_reset();
    end else if (en && md != MODE_HOLD) begin
      for (int i = 0; i < BW; i++) begin
        if (le[i]) begin
          if (md == MODE_SHL)
            m_lane[i] = (m_lane[i] * 2 + int'(inb[i])) % (2 ** DEPTH);
          else if (md == MODE_SHR)
            m_lane[i] = m_lane[i] / 2 + int'(inb[i]) * (2 ** (DEPTH - 1));
          else begin
            sl = ld[i*DEPTH +: DEPTH];
            m_lane[i] = int'(sl);
          end
        end
      end
      if (md == MODE_LOAD) m_fill = DEPTH;
      else m_fill = (m_fill + 1 > DEPTH) ? DEPTH : m_fill + 1;
    end
  endtask

  task automatic push_expect(input string tag);
    exp_t e;
    for (int i = 0; i < BW; i++) begin
      e.out[i*DEPTH +: DEPTH] = DEPTH'(m_lane[i]);
      e.msb[i] = (m_lane[i] >= 2 ** (DEPTH - 1));
      e.lsb[i] = (m_lane[i] % 2 == 1);
    end
    e.fill = m_fill;
    e.full = (m_fill == DEPTH);
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  // Drive one cycle of stimulus from a falling edge, queue its expectation
  task automatic step(input logic en, input logic [BW-1:0] le, input logic clr,
                      input logic [1:0] md, input logic [BW-1:0] inb,
                      input logic [BW*DEPTH-1:0] ld, input string tag);
    enable      = en;
    lane_enable = le;
    clear       = clr;
    mode        = md;
    in          = inb;
    load_data   = ld;
    model_step(en, le, clr, md, inb, ld);
    push_expect(tag);
    @(negedge clk);
  endtask

  // Monitor: output settles after each rising edge or reset assertion
  initial begin
    exp_t e;
    forever begin
      @(posedge clk or posedge reset);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        total += 5;
        if (out !== e.out) begin
          bad++; $display("FAIL %s out got=%h want=%h", e.tag, out, e.out);
        end
        if (msb_out !== e.msb) begin
          bad++; $display("FAIL %s msb_out got=%h want=%h", e.tag, msb_out, e.msb);
        end
        if (lsb_out !== e.lsb) begin
          bad++; $display("FAIL %s lsb_out got=%h want=%h", e.tag, lsb_out, e.lsb);
        end
        if (fill_count !== CW'(e.fill)) begin
          bad++; $display("FAIL %s fill_count got=%0d want=%0d", e.tag, fill_count, e.fill);
        end
        if (full !== e.full) begin
          bad++; $display("FAIL %s full got=%0d want=%0d", e.tag, full, e.full);
        end
      end
    end
  end

  initial begin
    logic [BW*DEPTH-1:0] ld;
    logic [1:0]          md;
    int                  waited;

    reset = 1'b0; enable = 1'b0; lane_enable = '0; clear = 1'b0;
    mode = MODE_HOLD; in = '0; load_data = '0;

    model_reset();
    push_expect("reset");
    #2 reset = 1'b1;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 10; c++) step(1, '1, 0, MODE_SHL, '1, '0, "shl_fill");

    ld = {$urandom, $urandom};
    ld[DEPTH-1:0] = 8'hA5;
    step(1, '1, 0, MODE_LOAD, '0, ld, "load_a5");
    for (int c = 0; c < 3; c++) step(1, '1, 0, MODE_SHR, '0, '0, "shr_a5");

    step(1, '1, 1, MODE_HOLD, '0, '0, "clear1");
    for (int c = 0; c < 2; c++) step(1, 8'h0F, 0, MODE_SHL, '1, '0, "mask_shl");

    step(1, '1, 1, MODE_LOAD, '1, '1, "clear_vs_load");
    step(1, '0, 0, MODE_SHR, '1, '0, "fill_no_lanes");

    step(1, '1, 0, MODE_LOAD, '0, {BW{8'h5A}}, "load_5a");
    #2;
    model_reset();
    push_expect("async_reset");
    reset = 1'b1;
    @(posedge clk); @(negedge clk);
    reset = 1'b0;
    step(1, '1, 0, MODE_SHL, '1, '0, "post_reset_shl");

    step(1, '1, 0, MODE_LOAD, '0, {$urandom, $urandom}, "pre_disable");
    for (int c = 0; c < 5; c++) step(0, '1, 0, MODE_SHL, BW'($urandom), '0, "disabled");

    for (int c = 0; c < 300; c++) begin
      md = 2'($urandom_range(0, 3));
      step(($urandom_range(0, 7) != 0), BW'($urandom), ($urandom_range(0, 15) == 0),
           md, BW'($urandom), {$urandom, $urandom}, "random");
    end

    waited = 0;
    while (exp_q.size() > 0 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain pending got=%0d want=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
